seq_addsub: RTL and testbench
=============================

# seq_addsub

Parametrised multi-cycle adder/subtractor with status flags. Each operation is computed CHUNK bits per clock over WIDTH/CHUNK cycles. A start/busy/done handshake controls it, and the block produces the same flag set as the team's 8-bit combinational adder: OF, SF, ZF, CF and cout. It is the wide-datapath arithmetic unit for the ALU/datapath projects, where WIDTH ≥ 32 makes a single-cycle ripple chain too slow.

## Interface
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- x  input  WIDTH  operand A; latched on accept.
- y  input  WIDTH  operand B; latched on accept.
- sub  input  1  0 = add, 1 = subtract; latched on accept.
- cin  input  1  carry-in for add, borrow-in for subtract; latched on accept.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- f  output  WIDTH  result.
- OF  output  1  signed overflow.
- SF  output  1  sign flag, f[WIDTH-1].
- ZF  output  1  1 when f == 0.
- CF  output  1  unsigned carry for add, borrow for subtract.
- cout  output  1  raw carry out of bit WIDTH-1.

## Operation
- Let N = WIDTH/CHUNK. Internal state:
  - FSM state, IDLE or RUN.
  - Chunk index k, range 0..N-1.
  - Latched x, y', carry c and sub.
  - Result shift register.
- Operand preparation on accept:
  - For add: y' = y and c = cin.
  - For subtract: y' = ~y and c = ~cin. The computation is x + ~y + 1 - cin, i.e. x - y - cin.
- IDLE:
  - start = 1 accepts the operation and latches the inputs.
  - Then k ← 0, busy ← 1, and the FSM moves to RUN.
- RUN, each cycle:
  - Add chunk k of x and y' with carry c.
  - Write the CHUNK-bit sum into result bits [k·CHUNK +: CHUNK].
  - c ← chunk carry-out, then k ← k+1.
- Final chunk (k = N-1), on the same edge:
  - Register f, and set cout = final carry.
  - CF = cout XOR sub.
  - OF = (carry into bit WIDTH-1) XOR cout.
  - SF = f[WIDTH-1].
  - ZF = (f == 0), evaluated over the full WIDTH.
  - busy ← 0, done ← 1, FSM returns to IDLE.
- Outputs f and all flags hold their values until the next operation's final edge. They do not change during RUN.
- start while busy = 1 is ignored; it is neither queued nor stored.
- start in the cycle done = 1 is accepted, since the FSM is in IDLE; back-to-back throughput is one operation per N+1 cycles.
- rst is highest priority:
  - State → IDLE, k → 0.
  - busy, done, f, OF, SF, ZF, CF and cout all → 0.
  - If asserted mid-operation, the operation is aborted and no done is produced.

## Timing
- Accept edge E0 is the edge where start = 1 and the FSM is in IDLE. busy is high from E0 through E_N, i.e. for N cycles.
- Chunk k is computed combinationally and registered at edge E(k+1).
- Results and flags are valid, and done = 1, from edge E_N for exactly one cycle of done. Latency is N cycles from accept.
- Degenerate case CHUNK = WIDTH (N = 1): busy for one cycle, done one cycle after accept.
- Reset values: busy = 0, done = 0, f = 0, all flags = 0.

## Structure
- Shared package `arith_pkg`, holding:
  - the FSM state enum {IDLE, RUN};
  - a localparam function computing N and the k counter width, $clog2(N) with a minimum of 1.
- Sub-module `addsub_chunk`:
  - CHUNK-bit ripple adder with inputs a, b, ci.
  - Outputs: s, co, and c_msb (the carry into its top bit, needed for OF).
  - Instantiated once and reused every cycle.
- The top-level module owns the FSM, operand/result registers and flag logic.

## Test plan
- Add with wrap, WIDTH=32, CHUNK=8: x=0xFFFFFFFF, y=1, sub=0, cin=0 → done exactly 4 cycles after accept; f=0, cout=1, CF=1, ZF=1, OF=0, SF=0.
- Signed overflow: x=0x7FFFFFFF, y=1, add → f=0x80000000, OF=1, SF=1, CF=0, ZF=0.
- Subtract:
  - x=5, y=7, sub=1, cin=0 → f=0xFFFFFFFE, cout=0, CF=1, SF=1, OF=0.
  - x=7, y=5 → f=2, cout=1, CF=0.
- Borrow-in: x=5, y=5, sub=1, cin=1 → f=0xFFFFFFFF, CF=1, ZF=0.
- Handshake:
  - start held high for 10 cycles → exactly two operations, accepted at cycles 0 and 5.
  - start pulsed during busy → ignored, and the previous f is unchanged until its own done.
- Reset and degenerate width:
  - rst at cycle 2 of an operation → busy=0, done never pulses, all outputs 0 on the next cycle.
  - With CHUNK=WIDTH=8, 0x80+0x80 → f=0, OF=1, CF=1 after one busy cycle.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared definitions for the multi-cycle arithmetic units.
//   state_t       - FSM state encoding {IDLE, RUN}
//   num_chunks()  - number of CHUNK-wide slices in a WIDTH-wide operand
//   cnt_width()   - width of a counter indexing those slices (minimum 1)
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk design still needs a 1-bit index register.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: CHUNK-bit ripple-carry adder slice.
//   a, b   - CHUNK-bit addends (b is pre-inverted by the caller for subtract)
//   ci     - carry in
//   s      - CHUNK-bit sum
//   co     - carry out of the top bit
//   c_msb  - carry into the top bit (signed overflow = c_msb ^ co)
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor, CHUNK bits per clock.
//   clk, rst         - clock, synchronous active-high reset
//   start            - request; sampled only while idle
//   x, y, sub, cin   - operands, op select (1 = subtract), carry/borrow in
//   busy             - operation in progress (N cycles)
//   done             - one-cycle pulse when f and flags update
//   f                - result, held until the next operation completes
//   OF, SF, ZF, CF   - signed overflow, sign, zero, unsigned carry/borrow
//   cout             - raw carry out of bit WIDTH-1
module seq_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             OF,
    output logic             SF,
    output logic             ZF,
    output logic             CF,
    output logic             cout
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int KW = cnt_width(N);

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;     // already inverted for subtract
    logic             c_r;
    logic             sub_r;
    logic [WIDTH-1:0] res;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;
    logic             cmsb_chunk;
    logic [WIDTH-1:0] res_next;
    logic             last;

    assign last = (k == KW'(N - 1));

    always_comb begin
        a_chunk  = x_r[int'(k) * CHUNK +: CHUNK];
        b_chunk  = y_r[int'(k) * CHUNK +: CHUNK];
        res_next = res;
        res_next[int'(k) * CHUNK +: CHUNK] = s_chunk;
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (c_r),
        .s     (s_chunk),
        .co    (co_chunk),
        .c_msb (cmsb_chunk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            x_r   <= '0;
            y_r   <= '0;
            c_r   <= 1'b0;
            sub_r <= 1'b0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            f     <= '0;
            OF    <= 1'b0;
            SF    <= 1'b0;
            ZF    <= 1'b0;
            CF    <= 1'b0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // x - y - cin == x + ~y + ~cin
                        x_r   <= x;
                        y_r   <= sub ? ~y : y;
                        c_r   <= sub ? ~cin : cin;
                        sub_r <= sub;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res <= res_next;
                    c_r <= co_chunk;
                    if (last) begin
                        // On the final chunk the slice top bit is bit WIDTH-1.
                        f     <= res_next;
                        cout  <= co_chunk;
                        CF    <= co_chunk ^ sub_r;
                        OF    <= cmsb_chunk ^ co_chunk;
                        SF    <= res_next[WIDTH-1];
                        ZF    <= (res_next == '0);
                        k     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 32-bit, 8-bit chunks (N = 4)
    logic        start, sub, cin, busy, done, OF, SF, ZF, CF, cout;
    logic [31:0] x, y, f;

    // degenerate 8-bit, single chunk (N = 1)
    logic        start8, sub8, cin8, busy8, done8, of8, sf8, zf8, cf8, cout8;
    logic [7:0]  x8, y8, f8;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .sub(sub), .cin(cin),
        .busy(busy), .done(done), .f(f), .OF(OF), .SF(SF), .ZF(ZF), .CF(CF), .cout(cout)
    );

    seq_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .sub(sub8), .cin(cin8),
        .busy(busy8), .done(done8), .f(f8), .OF(of8), .SF(sf8), .ZF(zf8), .CF(cf8), .cout(cout8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Flags packed as {cout, CF, OF, SF, ZF}
    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        sub;
        logic        cin;
        logic [31:0] ef;
        logic [4:0]  eflags;
    } vec_t;

    vec_t vecs[9];

    // Starts an op at posedge+1, returns cycles from accept edge to done (0 = timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic c, output int lat);
        x = a; y = b; sub = s; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int acc_n, acc0, acc1, done_n;
        logic prev_busy, saw_done;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 5'b11001};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 5'b00110};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 5'b01010};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 5'b10000};
        vecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'b01010};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 5'b00000};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 5'b10100};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 5'b10001};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 5'b11101};

        rst = 1'b1; start = 1'b0; x = '0; y = '0; sub = 1'b0; cin = 1'b0;
        start8 = 1'b0; x8 = '0; y8 = '0; sub8 = 1'b0; cin8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_f", f, 32'd0);
        chk("rst_flags", 32'({cout, CF, OF, SF, ZF}), 32'd0);
        chk("rst8_busy_done", 32'({busy8, done8}), 32'd0);
        chk("rst8_f_flags", 32'({f8, cout8, cf8, of8, sf8, zf8}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven main function
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].sub, vecs[i].cin, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("v%0d_f", i), f, vecs[i].ef);
            chk($sformatf("v%0d_flags", i), 32'({cout, CF, OF, SF, ZF}), 32'(vecs[i].eflags));
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
        end

        // start held high for 10 cycles: accepts at cycles 0 and 5 only
        x = 32'd10; y = 32'd3; sub = 1'b0; cin = 1'b0;
        acc_n = 0; acc0 = -1; acc1 = -1; done_n = 0; prev_busy = busy;
        start = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c == 9) start = 1'b0;
            if (busy && !prev_busy) begin
                if (acc_n == 0) acc0 = c;
                else if (acc_n == 1) acc1 = c;
                acc_n++;
            end
            if (done) done_n++;
            prev_busy = busy;
        end
        chk("hold_accepts", 32'(acc_n), 32'd2);
        chk("hold_accept0", 32'(acc0), 32'd0);
        chk("hold_accept1", 32'(acc1), 32'd5);
        chk("hold_dones", 32'(done_n), 32'd2);
        chk("hold_f", f, 32'd13);

        // start pulsed during busy is ignored and not queued
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        chk("pre_f", f, 32'h8000_0000);
        x = 32'd1; y = 32'd2; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        x = 32'hDEAD_BEEF; y = 32'h1111_1111; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b_hold_f_mid", f, 32'h8000_0000);
        chk("b_no_done_mid", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("b_hold_f_late", f, 32'h8000_0000);
        @(posedge clk); #1;
        chk("b_done", 32'(done), 32'd1);
        chk("b_f", f, 32'd3);
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (busy || done) saw_done = 1'b1;
        end
        chk("b_not_queued", 32'(saw_done), 32'd0);

        // reset in the middle of an operation
        x = 32'h0000_0100; y = 32'h0000_0023; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_f", f, 32'd0);
        chk("mid_rst_flags", 32'({cout, CF, OF, SF, ZF}), 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", 32'(saw_done), 32'd0);

        // degenerate single-chunk instance: 0x80 + 0x80
        x8 = 8'h80; y8 = 8'h80; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("d8_busy", 32'(busy8), 32'd1);
        chk("d8_no_done_yet", 32'(done8), 32'd0);
        @(posedge clk); #1;
        chk("d8_done", 32'(done8), 32'd1);
        chk("d8_busy_low", 32'(busy8), 32'd0);
        chk("d8_f", 32'(f8), 32'd0);
        chk("d8_flags", 32'({cout8, cf8, of8, sf8, zf8}), 32'(5'b11101));
        // 8-bit subtract 0x10 - 0x20 = 0xF0, borrow, no overflow
        x8 = 8'h10; y8 = 8'h20; sub8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("d8s_done", 32'(done8), 32'd1);
        chk("d8s_f", 32'(f8), 32'hF0);
        chk("d8s_flags", 32'({cout8, cf8, of8, sf8, zf8}), 32'(5'b01010));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
